// File: rtl/prbs_sync_checker.sv
// Self-synchronising PRBS checker: seeds an LFSR from the stream, verifies, then counts bits/errors.
// Latency 1: locked and counters reflect a word on the cycle after its data_in_valid edge.
// No backpressure: every valid word is consumed; idle (valid low) cycles change nothing.
//
// Ports: clk/rst (sync active-high), data_in[LANE_W] (bit 0 earliest), data_in_valid,
//        clear (zero counters, keep lock), locked, total_bits, total_bit_errors.
// Optional macro PRBS_CHK_INVERT_EN adds input 'invert' which bit-inverts data_in before use.
module prbs_sync_checker #(
  parameter int PRBS_ORDER = 31,
  parameter int LANE_W     = 1,
  parameter int CNT_W      = 32,
  parameter int LOCK_WORDS = 8,
  parameter int LOSS_ERRS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANE_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              clear,
`ifdef PRBS_CHK_INVERT_EN
  input  logic              invert,
`endif
  output logic              locked,
  output logic [CNT_W-1:0]  total_bits,
  output logic [CNT_W-1:0]  total_bit_errors
);

  // Second feedback tap of each supported polynomial; 1 marks an illegal order.
  localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                       (PRBS_ORDER == 15) ? 14 :
                       (PRBS_ORDER == 23) ? 18 :
                       (PRBS_ORDER == 31) ? 28 : 1;
  localparam int SEED_W = $clog2(PRBS_ORDER + 1);
  localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
  localparam int ERR_W  = $clog2(LOSS_ERRS + 1);
  // Four extra bits hold any LANE_W (<= 8) addend without overflow.
  localparam int SUM_W  = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = {4'b0, {CNT_W{1'b1}}};

  if (TAP == 1) begin : g_bad_order
    $error("prbs_sync_checker: PRBS_ORDER must be 7, 15, 23 or 31");
  end
  if (LANE_W < 1 || LANE_W > 8) begin : g_bad_lane
    $error("prbs_sync_checker: LANE_W must be in 1..8");
  end

  typedef enum logic [1:0] {SEED = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [PRBS_ORDER-1:0]   lfsr_q, lfsr_d;
  logic [SEED_W-1:0]       seed_cnt_q, seed_cnt_d;
  logic [GOOD_W-1:0]       good_cnt_q, good_cnt_d;
  logic [5:0]              win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]        bits_q, bits_d;
  logic [CNT_W-1:0]        errs_q, errs_d;

  logic [LANE_W-1:0]       din;
  logic [PRBS_ORDER-1:0]   lfsr_v;
  logic [SEED_W-1:0]       seed_v;
  logic                    seeding;
  logic                    pred;
  logic [LANE_W-1:0]       mism;
  logic [3:0]              n_err;
  logic                    word_err;
  logic [SUM_W-1:0]        bits_sum;
  logic [SUM_W-1:0]        errs_sum;

`ifdef PRBS_CHK_INVERT_EN
  assign din = data_in ^ {LANE_W{invert}};
`else
  assign din = data_in;
`endif

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_cnt_d = seed_cnt_q;
    good_cnt_d = good_cnt_q;
    win_cnt_d  = win_cnt_q;
    err_cnt_d  = err_cnt_q;
    bits_d     = bits_q;
    errs_d     = errs_q;
    lfsr_v     = lfsr_q;
    seed_v     = seed_cnt_q;
    seeding    = (state_q == SEED);
    pred       = 1'b0;
    mism       = '0;
    n_err      = '0;
    word_err   = 1'b0;
    bits_sum   = '0;
    errs_sum   = '0;

    if (data_in_valid) begin
      // Walk the lane serially. Seeding can finish part-way through a word; the
      // remaining bits of that word are then already checked against prediction.
      for (int i = 0; i < LANE_W; i++) begin
        pred = lfsr_v[PRBS_ORDER-1] ^ lfsr_v[TAP-1];
        if (seeding) begin
          lfsr_v = {lfsr_v[PRBS_ORDER-2:0], din[i]};
          seed_v = seed_v + SEED_W'(1);
          if (seed_v == SEED_W'(PRBS_ORDER)) seeding = 1'b0;
        end else begin
          mism[i] = pred ^ din[i];
          // The prediction, not the received bit, advances the LFSR so that
          // line errors never corrupt the reference sequence.
          lfsr_v  = {lfsr_v[PRBS_ORDER-2:0], pred};
        end
      end
      for (int i = 0; i < LANE_W; i++) n_err = n_err + {3'b0, mism[i]};
      word_err = (mism != '0);
      lfsr_d   = lfsr_v;

      case (state_q)
        SEED: begin
          if (seeding) begin
            seed_cnt_d = seed_v;
          end else begin
            // Seed complete; a bad tail bit in the same word restarts seeding.
            seed_cnt_d = '0;
            good_cnt_d = '0;
            state_d    = word_err ? SEED : VERIFY;
          end
        end
        VERIFY: begin
          if (word_err) begin
            state_d    = SEED;
            seed_cnt_d = '0;
            good_cnt_d = '0;
          end else if (good_cnt_q == GOOD_W'(LOCK_WORDS - 1)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
            win_cnt_d  = '0;
            err_cnt_d  = '0;
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
        LOCKED: begin
          bits_sum = {4'b0, bits_q} + SUM_W'(LANE_W);
          errs_sum = {4'b0, errs_q} + SUM_W'(n_err);
          bits_d   = (bits_sum > CNT_MAX) ? '1 : bits_sum[CNT_W-1:0];
          errs_d   = (errs_sum > CNT_MAX) ? '1 : errs_sum[CNT_W-1:0];
          if (word_err && (err_cnt_q >= ERR_W'(LOSS_ERRS - 1))) begin
            // Counters deliberately hold their values across loss of lock.
            state_d    = SEED;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            err_cnt_d  = '0;
          end else if (win_cnt_q == 6'd63) begin
            // 64th word of the window: start a fresh window.
            win_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 6'd1;
            err_cnt_d = err_cnt_q + ERR_W'(word_err);
          end
        end
        default: state_d = SEED;
      endcase
    end

    // Clear wins over a same-cycle increment.
    if (clear) begin
      bits_d = '0;
      errs_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEED;
      lfsr_q     <= '0;
      seed_cnt_q <= '0;
      good_cnt_q <= '0;
      win_cnt_q  <= '0;
      err_cnt_q  <= '0;
      bits_q     <= '0;
      errs_q     <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_cnt_q <= seed_cnt_d;
      good_cnt_q <= good_cnt_d;
      win_cnt_q  <= win_cnt_d;
      err_cnt_q  <= err_cnt_d;
      bits_q     <= bits_d;
      errs_q     <= errs_d;
    end
  end

  assign locked           = (state_q == LOCKED);
  assign total_bits       = bits_q;
  assign total_bit_errors = errs_q;

endmodule
